// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        EOP_SE0,
        EOP_J
    } state_t;

    // Line states as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int EOP_SE0_BITS = 2;
    localparam int EOP_J_BITS   = 1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; MSB selects which end is shifted out first.
module flex_pts_sr #(
    parameter int SIZE = 8,
    parameter int MSB  = 0
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            shift_enable,
    input  logic            load_enable,
    input  logic [SIZE-1:0] parallel_in,
    output logic            serial_out
);

    logic [SIZE-1:0] r_sr;

    generate
        if (MSB != 0) begin : g_msb_first
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst)            r_sr <= '1;
                else if (load_enable)  r_sr <= parallel_in;
                else if (shift_enable) r_sr <= {r_sr[SIZE-2:0], 1'b1};
            end
            assign serial_out = r_sr[SIZE-1];
        end else begin : g_lsb_first
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst)            r_sr <= '1;
                else if (load_enable)  r_sr <= parallel_in;
                else if (shift_enable) r_sr <= {1'b1, r_sr[SIZE-1:1]};
            end
            assign serial_out = r_sr[0];
        end
    endgenerate

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: byte handshake, LSB-first shifting, bit stuffing,
// NRZI encoding and EOP generation onto the D+/D- pair.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic                  d_plus,
    output logic                  d_minus,
    output logic                  tx_busy,
    output logic                  tx_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [BW-1:0]         r_bit_idx;
    logic [OW-1:0]         r_ones;
    logic                  r_level;
    logic                  r_cur_last;
    logic [1:0]            r_eop_cnt;
    logic [1:0]            r_line;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_hold_full;
    logic                  r_hold_last;
    logic [DATA_WIDTH-1:0] r_hold_data;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [BW-1:0] w_bit_idx_nxt;
    logic [OW-1:0] w_ones_nxt;
    logic          w_level_nxt;
    logic          w_cur_last_nxt;
    logic [1:0]    w_eop_nxt;
    logic [1:0]    w_line_nxt;
    logic          w_err_nxt;
    logic          w_load;
    logic          w_emit;
    logic          w_emit_bit;
    logic          w_serial;
    logic          w_accept;
    logic          w_hold_full_nxt;
    logic          w_bit_end;
    logic          w_pre_end;
    logic          w_stuff_due;
    logic          w_byte_done;
    logic          w_shift;

    assign w_accept    = tx_valid && !r_hold_full;
    assign w_bit_end   = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_pre_end   = (r_timer == TW'(CLKS_PER_BIT - 2));
    assign w_stuff_due = (r_ones == OW'(STUFF_LIMIT));
    assign w_byte_done = (r_bit_idx == BW'(DATA_WIDTH - 1));
    // Shift one cycle ahead of the bit boundary so serial_out already shows the
    // next data bit when the registered line value is computed.
    assign w_shift     = (r_state == SEND) && w_pre_end && !w_stuff_due && !w_byte_done;

    assign w_hold_full_nxt = w_accept || (r_hold_full && !w_load);

    flex_pts_sr #(
        .SIZE (DATA_WIDTH),
        .MSB  (0)
    ) u_pts_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (w_shift),
        .load_enable  (w_load),
        .parallel_in  (r_hold_data),
        .serial_out   (w_serial)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_bit_idx_nxt  = r_bit_idx;
        w_ones_nxt     = r_ones;
        w_level_nxt    = r_level;
        w_cur_last_nxt = r_cur_last;
        w_eop_nxt      = r_eop_cnt;
        w_err_nxt      = 1'b0;
        w_load         = 1'b0;
        w_emit         = 1'b0;
        w_emit_bit     = 1'b0;

        if (r_state != IDLE) begin
            w_timer_nxt = w_bit_end ? '0 : r_timer + TW'(1);
        end

        case (r_state)
            IDLE: begin
                w_level_nxt = 1'b1;
                w_ones_nxt  = '0;
                if (r_hold_full) begin
                    w_state_nxt    = SEND;
                    w_timer_nxt    = '0;
                    w_bit_idx_nxt  = '0;
                    w_cur_last_nxt = r_hold_last;
                    w_load         = 1'b1;
                    w_emit         = 1'b1;
                    w_emit_bit     = r_hold_data[0];
                end
            end
            SEND: begin
                if (w_bit_end) begin
                    if (w_stuff_due) begin
                        w_emit     = 1'b1;
                        w_emit_bit = 1'b0;
                    end else if (!w_byte_done) begin
                        w_emit        = 1'b1;
                        w_emit_bit    = w_serial;
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end else if (r_cur_last) begin
                        w_state_nxt = EOP_SE0;
                        w_eop_nxt   = '0;
                    end else if (r_hold_full) begin
                        w_bit_idx_nxt  = '0;
                        w_cur_last_nxt = r_hold_last;
                        w_load         = 1'b1;
                        w_emit         = 1'b1;
                        w_emit_bit     = r_hold_data[0];
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = EOP_SE0;
                        w_eop_nxt   = '0;
                    end
                end
            end
            EOP_SE0: begin
                if (w_bit_end) begin
                    if (r_eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                        w_state_nxt = EOP_J;
                        w_eop_nxt   = '0;
                    end else begin
                        w_eop_nxt = r_eop_cnt + 2'd1;
                    end
                end
            end
            EOP_J: begin
                if (w_bit_end) begin
                    if (r_eop_cnt == 2'(EOP_J_BITS - 1)) begin
                        w_state_nxt = IDLE;
                        w_eop_nxt   = '0;
                        w_ones_nxt  = '0;
                        w_level_nxt = 1'b1;
                    end else begin
                        w_eop_nxt = r_eop_cnt + 2'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // NRZI: a 0 (data or stuffed) toggles the level, a 1 holds it
        if (w_emit) begin
            w_level_nxt = w_emit_bit ? r_level : !r_level;
            w_ones_nxt  = w_emit_bit ? r_ones + OW'(1) : '0;
        end
    end

    always_comb begin
        w_line_nxt = LINE_J;
        case (w_state_nxt)
            SEND:    w_line_nxt = w_level_nxt ? LINE_J : LINE_K;
            EOP_SE0: w_line_nxt = LINE_SE0;
            default: w_line_nxt = LINE_J;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_ones      <= '0;
            r_level     <= 1'b1;
            r_cur_last  <= 1'b0;
            r_eop_cnt   <= '0;
            r_line      <= LINE_J;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_ones      <= w_ones_nxt;
            r_level     <= w_level_nxt;
            r_cur_last  <= w_cur_last_nxt;
            r_eop_cnt   <= w_eop_nxt;
            r_line      <= w_line_nxt;
            r_ready     <= !w_hold_full_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_err       <= w_err_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_data <= tx_data;
            r_hold_last <= tx_last;
        end
    end

    assign d_plus   = r_line[1];
    assign d_minus  = r_line[0];
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_error = r_err;

endmodule
